bcd_to_bin: RTL

Sequential BCD-to-binary converter (reverse double-dabble) for the Pong datapath. Converts a 4-digit packed BCD value, such as a target score or setting entered as decimal digits on board switches, into a 14-bit unsigned binary value for the game logic. Processes one shift-and-correct iteration per clock under a start/busy/done handshake, and flags illegal BCD digits.

---
 rtl/bcd_to_bin.sv | 118 +++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit packed-BCD to binary converter (reverse double-dabble),
// one shift-and-correct iteration per clock, with illegal-digit detection.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is sampled only while idle (busy=0); a start seen while
  // busy=1 is dropped, not queued. done pulses for exactly one cycle and bin/err
  // change on that same edge, then hold until the next done.

  localparam int WS_W  = 4 * DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e            state_q;
  logic [WS_W-1:0]   ws_q;
  logic [WS_W-1:0]   ws_shift;
  logic [WS_W-1:0]   ws_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIN_W-1:0]  bin_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (BCD[4*d +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  // Correction is applied to the already-shifted value within the same cycle.
  always_comb begin
    ws_shift = ws_q >> 1;
    ws_d     = ws_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (ws_shift[BIN_W + 4*d +: 4] >= 4'd8) begin
        ws_d[BIN_W + 4*d +: 4] = ws_shift[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ws_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (bcd_bad) begin
              state_q <= S_ERR;
            end else begin
              ws_q    <= {BCD, {BIN_W{1'b0}}};
              cnt_q   <= '0;
              state_q <= S_CONV;
            end
          end
        end
        S_CONV: begin
          ws_q  <= ws_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            bin_q   <= ws_d[BIN_W-1:0];
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          bin_q   <= '0;
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bin         = bin_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
